// File: rtl/stereo_census_stream_if.sv
// stereo_census_stream_if: pixel-pair input and disparity result bundle.
// Optional macro STEREO_UNIQ_CHECK_EN adds the out_conf result field.
interface stereo_census_stream_if #(
   parameter int WIDTH     = 8,
   parameter int WIN       = 11,
   parameter int DISPARITY = 80
);
   localparam int DISP_W = $clog2(DISPARITY);
   localparam int COST_W = $clog2(WIN * WIN + 1);

   logic              in_valid;
   logic              in_sof;
   logic [WIDTH-1:0]  inp_left;
   logic [WIDTH-1:0]  inp_right;
   logic              out_valid;
   logic [DISP_W-1:0] out_disp;
   logic [COST_W-1:0] out_cost;
   logic              out_mask;
   logic              out_eof;
`ifdef STEREO_UNIQ_CHECK_EN
   logic              out_conf;
`endif

   // pixel source / result sink side
   modport master (
      output in_valid, in_sof, inp_left, inp_right,
      input  out_valid, out_disp, out_cost, out_mask, out_eof
`ifdef STEREO_UNIQ_CHECK_EN
      , out_conf
`endif
   );

   // census matcher side
   modport slave (
      input  in_valid, in_sof, inp_left, inp_right,
      output out_valid, out_disp, out_cost, out_mask, out_eof
`ifdef STEREO_UNIQ_CHECK_EN
      , out_conf
`endif
   );
endinterface

// File: rtl/stereo_census_stream.sv
// stereo_census_stream: stall-capable census stereo matcher, 3-stage pipeline.
// Optional macro STEREO_UNIQ_CHECK_EN adds the second-minimum uniqueness flag.
module stereo_census_stream #(
   parameter int WIDTH       = 8,
   parameter int LINE_LENGTH = 640,
   parameter int NUM_LINES   = 480,
   parameter int WIN         = 11,
   parameter int DISPARITY   = 80,
   parameter int UNIQ_MARGIN = 2
) (
   input logic                  clk,
   input logic                  rst,
   stereo_census_stream_if.slave bus
);
   localparam int H        = WIN / 2;
   localparam int NB       = WIN * WIN - 1;
   localparam int CENTRE   = H * WIN + H;
   localparam int DISP_W   = $clog2(DISPARITY);
   localparam int COST_W   = $clog2(WIN * WIN + 1);
   localparam int COL_W    = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
   localparam int ROW_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int MASK_COL = 2 * H + DISPARITY - 1;

   typedef logic [WIN-1:0][WIN-1:0][WIDTH-1:0] win_t;

   // census: bit set when a neighbour is darker than the window centre
   function automatic logic [NB-1:0] census(input win_t w);
      logic [NB-1:0] bits;
      bits = '0;
      for (int i = 0; i < WIN; i++) begin
         for (int j = 0; j < WIN; j++) begin
            if (i * WIN + j < CENTRE)
               bits[i * WIN + j] = (w[i][j] < w[H][H]);
            else if (i * WIN + j > CENTRE)
               bits[i * WIN + j - 1] = (w[i][j] < w[H][H]);
         end
      end
      return bits;
   endfunction

   function automatic logic [COST_W-1:0] popcount(input logic [NB-1:0] x);
      logic [COST_W-1:0] n;
      n = '0;
      for (int k = 0; k < NB; k++)
         n = n + COST_W'(x[k]);
      return n;
   endfunction

   logic [ROW_W-1:0] row_q, cur_row;
   logic [COL_W-1:0] col_q, cur_col;
   logic             px_mask, px_eof;

   logic [WIN-2:0][LINE_LENGTH-1:0][WIDTH-1:0] lb_l, lb_r;
   logic [WIN-1:0][WIN-2:0][WIDTH-1:0]         win_l, win_r;
   win_t                                       wn_l, wn_r;

   logic [NB-1:0] cen_l, cen_r;
   logic          s1_valid, s1_mask, s1_eof;

   logic [DISPARITY-2:0][NB-1:0] hist;
   logic [DISPARITY-1:0][NB-1:0] tap;

   logic [DISPARITY-1:0][COST_W-1:0] cost;
   logic                             s2_valid, s2_mask, s2_eof;

   logic [COST_W-1:0] best_cost;
   logic [DISP_W-1:0] best_disp;
`ifdef STEREO_UNIQ_CHECK_EN
   logic [COST_W-1:0] sec_cost;
`else
   // margin only matters when the uniqueness flag is built
   logic unused_margin;
   assign unused_margin = (UNIQ_MARGIN > 0);
`endif

   // position of the pixel on the bus; sof overrides the counters
   always_comb begin
      cur_row = bus.in_sof ? '0 : row_q;
      cur_col = bus.in_sof ? '0 : col_q;
      px_mask = (int'(cur_row) < 2 * H) || (int'(cur_col) < MASK_COL);
      px_eof  = (int'(cur_row) == NUM_LINES - 1) &&
                (int'(cur_col) == LINE_LENGTH - 1);
   end

   // row/col counters advance once per accepted pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else if (bus.in_valid) begin
         if (int'(cur_col) == LINE_LENGTH - 1) begin
            col_q <= '0;
            if (int'(cur_row) == NUM_LINES - 1)
               row_q <= '0;
            else
               row_q <= cur_row + ROW_W'(1);
         end else begin
            col_q <= cur_col + COL_W'(1);
            row_q <= cur_row;
         end
      end
   end

   // line buffers: column cur_col slides one row deeper per accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lb_l <= '0;
         lb_r <= '0;
      end else if (bus.in_valid) begin
         lb_l[0][cur_col] <= bus.inp_left;
         lb_r[0][cur_col] <= bus.inp_right;
         for (int k = 1; k < WIN - 1; k++) begin
            lb_l[k][cur_col] <= lb_l[k-1][cur_col];
            lb_r[k][cur_col] <= lb_r[k-1][cur_col];
         end
      end
   end

   // window including the incoming column; [i][j] is pixel (r-i, c-j)
   always_comb begin
      wn_l = '0;
      wn_r = '0;
      wn_l[0][0] = bus.inp_left;
      wn_r[0][0] = bus.inp_right;
      for (int i = 1; i < WIN; i++) begin
         wn_l[i][0] = lb_l[i-1][cur_col];
         wn_r[i][0] = lb_r[i-1][cur_col];
      end
      for (int i = 0; i < WIN; i++) begin
         for (int j = 1; j < WIN; j++) begin
            wn_l[i][j] = win_l[i][j-1];
            wn_r[i][j] = win_r[i][j-1];
         end
      end
   end

   // window register keeps the WIN-1 most recent columns
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_l <= '0;
         win_r <= '0;
      end else if (bus.in_valid) begin
         for (int i = 0; i < WIN; i++) begin
            win_l[i] <= wn_l[i][WIN-2:0];
            win_r[i] <= wn_r[i][WIN-2:0];
         end
      end
   end

   // S1: registered census transforms plus position tags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cen_l    <= '0;
         cen_r    <= '0;
         s1_valid <= 1'b0;
         s1_mask  <= 1'b0;
         s1_eof   <= 1'b0;
      end else if (bus.in_valid) begin
         cen_l    <= census(wn_l);
         cen_r    <= census(wn_r);
         s1_valid <= 1'b1;
         s1_mask  <= px_mask;
         s1_eof   <= px_eof;
      end
   end

   // left census history; hist[k] is tap k+1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
      end else if (bus.in_valid) begin
         hist[0] <= cen_l;
         for (int k = 1; k < DISPARITY - 1; k++)
            hist[k] <= hist[k-1];
      end
   end

   // tap d: left census from d accepted pixels earlier
   always_comb begin
      tap    = '0;
      tap[0] = cen_l;
      for (int d = 1; d < DISPARITY; d++)
         tap[d] = hist[d-1];
   end

   // S2: Hamming cost against every candidate disparity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cost     <= '0;
         s2_valid <= 1'b0;
         s2_mask  <= 1'b0;
         s2_eof   <= 1'b0;
      end else if (bus.in_valid) begin
         for (int d = 0; d < DISPARITY; d++)
            cost[d] <= popcount(cen_r ^ tap[d]);
         s2_valid <= s1_valid;
         s2_mask  <= s1_mask;
         s2_eof   <= s1_eof;
      end
   end

   // argmin; strict compare keeps the lowest disparity on ties
   always_comb begin
      best_cost = cost[0];
      best_disp = '0;
`ifdef STEREO_UNIQ_CHECK_EN
      sec_cost  = '1;
`endif
      for (int d = 1; d < DISPARITY; d++) begin
         if (cost[d] < best_cost) begin
`ifdef STEREO_UNIQ_CHECK_EN
            sec_cost  = best_cost;
`endif
            best_cost = cost[d];
            best_disp = DISP_W'(d);
         end
`ifdef STEREO_UNIQ_CHECK_EN
         else if (cost[d] < sec_cost) begin
            sec_cost = cost[d];
         end
`endif
      end
   end

   // S3: registered result; valid pulses only on accepting cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_disp  <= '0;
         bus.out_cost  <= '0;
         bus.out_mask  <= 1'b0;
         bus.out_eof   <= 1'b0;
`ifdef STEREO_UNIQ_CHECK_EN
         bus.out_conf  <= 1'b0;
`endif
      end else begin
         bus.out_valid <= bus.in_valid && s2_valid;
         if (bus.in_valid) begin
            bus.out_mask <= s2_mask;
            bus.out_eof  <= s2_eof;
            bus.out_disp <= s2_mask ? '0 : best_disp;
            bus.out_cost <= s2_mask ? '1 : best_cost;
`ifdef STEREO_UNIQ_CHECK_EN
            bus.out_conf <= !s2_mask &&
               ((int'(sec_cost) - int'(best_cost)) >= UNIQ_MARGIN);
`endif
         end
      end
   end
endmodule

// File: doc/stereo_census_stream.md
Name: stereo_census_stream

Overview:
- Parametrised, stall-capable successor to the fixed 640-wide, 11x11, 80-disparity census stereo top.
- Accepts a left/right pixel stream with a valid qualifier and start-of-frame marker, and tracks row and column internally.
- Per output pixel, emits winner disparity, winning Hamming cost, a border-invalid mask and end-of-frame marker.
- Sits between the camera deserialiser and the disparity post-filter.

Parameters:
- WIDTH, 8, pixel bit width
- LINE_LENGTH, 640, pixels per line
- NUM_LINES, 480, lines per frame
- WIN, 11, square census window side; odd, >=3
- DISPARITY, 80, number of candidate disparities, >=2
- UNIQ_MARGIN, 2, minimum (second_min - min) for a confident match; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel pair accepted this cycle; the whole pipeline advances only when high
- in_sof  in  1  qualified by in_valid; this pixel pair is row 0, column 0
- inp_left  in  WIDTH  left pixel
- inp_right  in  WIDTH  right pixel
- out_valid  out  1  one-cycle pulse; output fields valid
- out_disp  out  $clog2(DISPARITY)  winning disparity
- out_cost  out  COST_W  winning Hamming cost; COST_W = $clog2(WIN*WIN+1)
- out_mask  out  1  1 = result invalid (border)
- out_eof  out  1  result belongs to the last pixel position of the frame
- out_conf  out  1  uniqueness pass; present only with UNIQ_CHECK_EN

Behaviour:
- Reset (async, active-high): all outputs 0, row/col counters 0, line buffers, census and history registers cleared. Reset mid-frame discards all in-flight data; the first pixel after reset is (0,0).
- Position: counters advance on in_valid. col wraps at LINE_LENGTH-1 and increments row; row wraps at NUM_LINES-1 to 0. in_sof with in_valid forces the current pixel to (0,0) and the next to (0,1), overriding the counters. in_sof without in_valid is ignored.
- Window: H = WIN/2. After accepting pixel (r,c), the window centre is (r-H, c-H).
- Pipeline, all stages clock-enabled by in_valid:
  - S1: registered census of both windows. Bit = 1 when neighbour < centre; WIN*WIN-1 bits, centre excluded.
  - Left census history shift register, depth DISPARITY. Tap d is the left census from d accepted pixels earlier.
  - S2: registered cost[d] = popcount(right_census ^ left_tap[d]) for all d.
  - S3: registered argmin over d. Ties resolve to the lowest d. Second-minimum is tracked over d != winner.
- out_valid pulses on the clock edge of the in_valid cycle that completes S3, i.e. 3 accepted pixels after the input. No output on cycles without in_valid. Row/col/eof tags are carried alongside the data.
- Mask: out_mask = 1 when tagged r < 2H, or tagged c < 2H+DISPARITY-1. When masked, out_disp = 0 and out_cost = all ones.
- out_eof = 1 for the result tagged (NUM_LINES-1, LINE_LENGTH-1).
- Line buffers never straddle a stall; a gap of any length in in_valid has no effect on results.

Optional Feature:
- Macro: STEREO_UNIQ_CHECK_EN
- Defined:
  - out_conf port exists.
  - out_conf = 1 iff not masked and (second_min - min) >= UNIQ_MARGIN.
  - Registered in S3; reset 0.
- Undefined:
  - out_conf port is absent.
  - No second-minimum logic is synthesised.
  - All other behaviour is identical.

Test Plan (LINE_LENGTH=16, NUM_LINES=8, WIN=3, DISPARITY=4 unless stated):
- Identical left/right ramp image, continuous in_valid -> every unmasked out_disp=0, out_cost=0; out_mask=1 exactly for r<2 or c<5; one out_eof per frame at (7,15).
- Right image = left shifted so right(x) = left(x-2), textured random image -> unmasked out_disp=2, out_cost=0.
- Same stimulus as above with in_valid deasserted on random 50% of cycles -> output sequence bit-identical to the continuous run; out_valid count = accepted pixels.
- Flat uniform image (all costs equal) -> out_disp=0 (lowest-index tie); with STEREO_UNIQ_CHECK_EN and UNIQ_MARGIN=2, out_conf=0.
- in_sof asserted at col 9 of row 3 -> next pixel tagged (0,1); rows 0-1 of the new frame masked; out_eof appears only after a full new frame.
- rst pulsed for 1 cycle mid-frame, asynchronously between edges -> outputs 0 immediately; the next output appears after the 3rd accepted pixel, tagged (0,0) relative to the restart, masked.
